// File: rtl/ides16_fclk.sv
// -----------------------------------------------------------------------------
// ides16_fclk
//
// Single-clock 1:16 DDR deserializer. It is the receive-side partner of a 16:1
// DDR serializer. D is sampled on both FCLK edges. The bits are collected into
// 16-bit words, LSB first, and a word is presented every 8 FCLK cycles together
// with a one-cycle Q_VALID strobe. Downstream logic runs on FCLK and uses
// Q_VALID as its enable, so no divided parallel clock is needed. Word alignment
// is adjusted one bit at a time by rising edges on CALIB.
//
// Parameters
//   GSREN  : global set/reset enable. It is kept for drop-in compatibility with
//            the vendor primitive. The global net is not modelled and is held
//            inactive.
//   LSREN  : "true" honours RESET. Any other value ignores RESET, so only the
//            power-up state applies.
//
// Ports
//   FCLK      in   fast serial clock (both edges sample D)
//   RESET     in   asynchronous active-high reset, gated by LSREN
//   D         in   DDR serial data
//   CALIB     in   bit-slip request, acts on its rising edge
//   Q0..Q15   out  deserialized word, Q0 = earliest bit in time
//   Q_VALID   out  one-cycle strobe when Q0..Q15 is updated
//   SLIP      out  current bit-slip offset, 0..15
// -----------------------------------------------------------------------------
module ides16_fclk #(
    parameter string GSREN = "false",
    parameter string LSREN = "true"
) (
    input  logic       FCLK,
    input  logic       RESET,
    input  logic       D,
    input  logic       CALIB,
    output logic       Q0,
    output logic       Q1,
    output logic       Q2,
    output logic       Q3,
    output logic       Q4,
    output logic       Q5,
    output logic       Q6,
    output logic       Q7,
    output logic       Q8,
    output logic       Q9,
    output logic       Q10,
    output logic       Q11,
    output logic       Q12,
    output logic       Q13,
    output logic       Q14,
    output logic       Q15,
    output logic       Q_VALID,
    output logic [3:0] SLIP
);

    localparam bit LSR_EN = (LSREN == "true");
    localparam bit GSR_EN = (GSREN == "true");

    // The device-wide set/reset net exists only in silicon. It is held
    // inactive here, so GSREN has no effect on behaviour.
    logic gsr;
    assign gsr = 1'b0;

    logic rst;
    assign rst = (LSR_EN & RESET) | (GSR_EN & gsr);

    // State
    logic        d_neg_q;
    logic [31:0] h_q,        h_d;
    logic [2:0]  cnt_q,      cnt_d;
    logic [3:0]  lock_q,     lock_d;
    logic [3:0]  slip_q,     slip_d;
    logic        calib_d_q,  calib_d_d;
    logic        rstn_cnt_q, rstn_cnt_d;
    logic [15:0] q_q,        q_d;
    logic        q_valid_q,  q_valid_d;

    // Combinational helpers
    logic        frame_end;
    logic        calib_rise;
    logic [4:0]  win_shift;
    logic [31:0] h_win;

    // The falling-edge sample is the earlier bit of each FCLK cycle.
    always_ff @(negedge FCLK or posedge rst) begin
        if (rst) begin
            d_neg_q <= 1'b0;
        end else begin
            d_neg_q <= D;
        end
    end

    always_comb begin
        // Newest bits enter at the top. The falling-edge bit is older, so it
        // lands one position below the rising-edge bit.
        h_d = {D, d_neg_q, h_q[31:2]};

        // Run flop. After reset it sets on the first clock, and framing counts
        // from there. This makes the strobe phase depend only on when reset is
        // released.
        rstn_cnt_d = 1'b1;
        cnt_d      = rstn_cnt_q ? cnt_q + 3'd1 : 3'd0;
        frame_end  = rstn_cnt_q && (cnt_q == 3'd7);

        // The word window ends SLIP bits below the newest bit. The old slip_q
        // is used on purpose: a slip accepted on a load edge only affects the
        // next word.
        win_shift = 5'd16 - {1'b0, slip_q};
        h_win     = h_q >> win_shift;

        q_d       = frame_end ? h_win[15:0] : q_q;
        q_valid_d = frame_end;

        // Bit-slip. Only a CALIB rising edge is a request. While the lockout
        // counter runs, requests are dropped, not queued. This stops a slow or
        // bouncing CALIB from slipping more than once per request.
        calib_d_d  = CALIB;
        calib_rise = CALIB & ~calib_d_q;
        slip_d     = slip_q;
        lock_d     = lock_q;
        if (calib_rise && (lock_q == 4'd0)) begin
            slip_d = slip_q + 4'd1;
            lock_d = 4'd15;
        end else if (lock_q != 4'd0) begin
            lock_d = lock_q - 4'd1;
        end
    end

    always_ff @(posedge FCLK or posedge rst) begin
        if (rst) begin
            h_q        <= '0;
            cnt_q      <= '0;
            lock_q     <= '0;
            slip_q     <= '0;
            calib_d_q  <= 1'b0;
            rstn_cnt_q <= 1'b0;
            q_q        <= '0;
            q_valid_q  <= 1'b0;
        end else begin
            h_q        <= h_d;
            cnt_q      <= cnt_d;
            lock_q     <= lock_d;
            slip_q     <= slip_d;
            calib_d_q  <= calib_d_d;
            rstn_cnt_q <= rstn_cnt_d;
            q_q        <= q_d;
            q_valid_q  <= q_valid_d;
        end
    end

    assign Q0      = q_q[0];
    assign Q1      = q_q[1];
    assign Q2      = q_q[2];
    assign Q3      = q_q[3];
    assign Q4      = q_q[4];
    assign Q5      = q_q[5];
    assign Q6      = q_q[6];
    assign Q7      = q_q[7];
    assign Q8      = q_q[8];
    assign Q9      = q_q[9];
    assign Q10     = q_q[10];
    assign Q11     = q_q[11];
    assign Q12     = q_q[12];
    assign Q13     = q_q[13];
    assign Q14     = q_q[14];
    assign Q15     = q_q[15];
    assign Q_VALID = q_valid_q;
    assign SLIP    = slip_q;

endmodule
